// File: rtl/mdu_ctrl_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Holds the funct3 op encoding, the FSM state type and the corner-case result values.
package m_types;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam logic [XLEN-1:0] DIV0_QUO = '1;
  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;

  function automatic logic is_div_op(input m_funct3_t op);
    return op[2];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic has_signed_a(input m_funct3_t op);
    return (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
  endfunction

  function automatic logic has_signed_b(input m_funct3_t op);
    return (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface mdu_ctrl_if #(
  parameter int WIDTH = 32
) ();

  logic             req;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             advance;
  logic             flush;
  logic [WIDTH-1:0] m_out;
  logic             m_ready;
  logic             busy;

  modport master (
    output req, funct3, a, b, advance, flush,
    input  m_out, m_ready, busy
  );

  modport slave (
    input  req, funct3, a, b, advance, flush,
    output m_out, m_ready, busy
  );

endinterface

// File: rtl/mdu_ctrl_divstep.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_ext;
  logic [WIDTH:0] trial;
  logic           keep;

  // The shifted partial remainder is below 2*divisor, so WIDTH+1 bits hold it
  // and the trial difference's top bit is a clean borrow flag.
  always_comb begin
    rem_ext = {rem_i, quo_i[WIDTH-1]};
    trial   = rem_ext - {1'b0, divisor_i};
    keep    = ~trial[WIDTH];
    rem_o   = keep ? trial[WIDTH-1:0] : rem_ext[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], keep};
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative RV32M sequencer: 32-step shift-add multiply or restoring divide,
// result held on m_out with m_ready high until the pipeline advances.
module mdu_ctrl
  import m_types::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEPS_LOG2 = 5
) (
  input  logic      clk,
  input  logic      rst,
  mdu_ctrl_if.slave bus
);

  localparam logic [STEPS_LOG2-1:0] LAST_STEP = STEPS_LOG2'(WIDTH - 1);
  localparam logic [WIDTH-1:0]      MIN_VAL   = WIDTH'(INT_MIN);
  localparam logic [WIDTH-1:0]      QUO_DIV0  = WIDTH'(DIV0_QUO);

  mdu_state_t            state_q, state_d;
  logic [STEPS_LOG2-1:0] cnt_q, cnt_d;
  m_funct3_t             op_q, op_d;
  logic [2*WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]      opnd_q, opnd_d;
  logic                  neg_res_q, neg_res_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]      m_out_q, m_out_d;

  m_funct3_t          req_op;
  logic               req_sa, req_sb, req_div0, req_ovf, req_fast;
  logic [WIDTH-1:0]   req_abs_a, req_abs_b, req_fast_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, step_acc, prod;
  logic [WIDTH-1:0]   div_rem, div_quo, quo_fix, rem_fix, fix_res;
  logic               last_step, m_ready, busy;

  // Request decode: sign flags, magnitudes and the two results known up front.
  always_comb begin
    req_op    = m_funct3_t'(bus.funct3);
    req_sa    = bus.a[WIDTH-1] & has_signed_a(req_op);
    req_sb    = bus.b[WIDTH-1] & has_signed_b(req_op);
    req_abs_a = req_sa ? -bus.a : bus.a;
    req_abs_b = req_sb ? -bus.b : bus.b;
    req_div0  = is_div_op(req_op) && (bus.b == '0);
    req_ovf   = ((req_op == F3_DIV) || (req_op == F3_REM)) && (bus.a == MIN_VAL) && (bus.b == '1);
    req_fast  = req_div0 | req_ovf;
    if (req_div0) req_fast_res = req_op[1] ? bus.a : QUO_DIV0;
    else          req_fast_res = req_op[1] ? '0 : MIN_VAL;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
  end

  // Divide: acc = {partial remainder, dividend/quotient shift register}.
  mdu_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .quo_i     (acc_q[WIDTH-1:0]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  // Sign fixup and word select applied to the final step's outputs.
  always_comb begin
    step_acc  = is_div_op(op_q) ? {div_rem, div_quo} : mul_next;
    prod      = neg_res_q ? -step_acc : step_acc;
    quo_fix   = neg_res_q ? -div_quo : div_quo;
    rem_fix   = neg_rem_q ? -div_rem : div_rem;
    last_step = (cnt_q == LAST_STEP);
    case (op_q)
      F3_MUL:                       fix_res = prod[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req) state_d = req_fast ? DONE : BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (bus.advance) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // An idle unit with no request must not hold up all_ready.
  always_comb begin
    m_ready = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE:    m_ready = ~bus.req;
      BUSY:    busy    = 1'b1;
      DONE:    m_ready = 1'b1;
      default: m_ready = 1'b0;
    endcase
  end

  assign bus.m_ready = m_ready;
  assign bus.busy    = busy;
  assign bus.m_out   = m_out_q;

  // Operands are captured only on the IDLE accept; later bus changes are ignored.
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    m_out_d   = m_out_q;
    if (bus.flush) begin
      cnt_d   = '0;
      m_out_d = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req) begin
          op_d      = req_op;
          cnt_d     = '0;
          neg_res_d = req_sa ^ req_sb;
          neg_rem_d = req_sa;
          if (is_div_op(req_op)) begin
            acc_d  = {{WIDTH{1'b0}}, req_abs_a};
            opnd_d = req_abs_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, req_abs_b};
            opnd_d = req_abs_a;
          end
          if (req_fast) m_out_d = req_fast_res;
        end
        BUSY: begin
          acc_d = step_acc;
          cnt_d = cnt_q + STEPS_LOG2'(1);
          if (last_step) m_out_d = fix_res;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: every register, datapath included, is cleared on rst; these are flops, not a RAM.
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= F3_MUL;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      m_out_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      m_out_q   <= m_out_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed RV32M cases, random operands,
// hold/advance handshakes and flush/reset aborts against an arithmetic model.
module tb_mdu_ctrl;
  import m_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_ctrl_if #(.WIDTH(32)) bus ();

  mdu_ctrl #(
    .WIDTH      (32),
    .STEPS_LOG2 (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from plain 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: a result is consumed when the pipeline advances on a ready request.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.req && bus.advance && bus.m_ready && !bus.flush) begin
        if (exp_q.size() == 0) check("unexpected result, queue depth", 32'(exp_q.size()), 32'd1);
        else                   check("result", bus.m_out, exp_q.pop_front());
      end
    end
  end

  // Called right after a posedge; returns right after the posedge ending the advance cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          lat;
    exp = model(f3, a, b);
    exp_q.push_back(exp);
    bus.funct3  = f3;
    bus.a       = a;
    bus.b       = b;
    bus.req     = 1'b1;
    bus.advance = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        bus.a      = $urandom;
        bus.b      = $urandom;
        bus.funct3 = 3'($urandom);
      end
      @(negedge clk);
    end while (!bus.m_ready && lat < 100);
    check("latency", 32'(lat), 32'(model_latency(f3, a, b)));
    if (!bus.m_ready) begin
      void'(exp_q.pop_back());
      bus.req = 1'b0;
      @(posedge clk); #1;
      return;
    end
    check("first m_out", bus.m_out, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold m_ready", 32'(bus.m_ready), 32'd1);
      check("hold m_out", bus.m_out, exp);
    end
    @(posedge clk); #1;
    bus.advance = 1'b1;
    @(posedge clk); #1;
    bus.advance = 1'b0;
    bus.req     = 1'b0;
  endtask

  task automatic abort_op(input int busy_cycles, input logic use_rst);
    bus.funct3 = 3'(F3_MUL);
    bus.a      = 32'h1234_5678;
    bus.b      = 32'h0BAD_F00D;
    bus.req    = 1'b1;
    repeat (busy_cycles) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("busy before abort", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    if (use_rst) begin
      rst     = 1'b1;
      bus.req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst abort busy", 32'(bus.busy), 32'd0);
      check("rst abort m_ready", 32'(bus.m_ready), 32'd1);
      check("rst abort m_out", bus.m_out, 32'd0);
    end else begin
      bus.flush = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("flush busy", 32'(bus.busy), 32'd0);
      check("flush no m_ready pulse", 32'(bus.m_ready), 32'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.req   = 1'b0;
      @(negedge clk);
      check("post-flush idle m_ready", 32'(bus.m_ready), 32'd1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.req     = 1'b0;
    bus.funct3  = 3'd0;
    bus.a       = 32'd0;
    bus.b       = 32'd0;
    bus.advance = 1'b0;
    bus.flush   = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset m_ready", 32'(bus.m_ready), 32'd1);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset m_out", bus.m_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 0);
    run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 1);
    run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         0);
    run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,         0);
    run_op(F3_REM,    32'hFFFF_FFF9,  32'd2,         0);
    run_op(F3_DIVU,   32'd100,        32'd7,         3);
    run_op(F3_REMU,   32'd100,        32'd7,         0);
    run_op(F3_DIVU,   32'h0000_1234,  32'd0,         0);
    run_op(F3_REM,    32'd5,          32'd0,         2);
    run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op(F3_MULH,   32'h8000_0000,  32'h8000_0000, 0);
    run_op(F3_DIV,    32'h8000_0000,  32'd1,         0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 2));
    end

    abort_op(10, 1'b0);
    run_op(F3_MUL, 32'd3, 32'd4, 0);
    abort_op(20, 1'b1);
    run_op(F3_MUL, 32'd3, 32'd4, 0);

    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
